// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM encoding, derived
// geometry widths, the result tag record and the datapath pipeline depth.
package conv_pkg;

    // Registers between the datapath input and conv_data_out: one multiplier
    // register plus five adder-tree levels. Must track the datapath.
    localparam int PIPE_LATENCY = 6;

    // Default layer geometry of the unit this sequencer was built for.
    localparam int DEF_IFM_SIZE          = 14;
    localparam int DEF_IFM_DEPTH         = 3;
    localparam int DEF_KERNAL_SIZE       = 5;
    localparam int DEF_NUMBER_OF_FILTERS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Output feature map side length.
    function automatic int calc_os(input int ifm_size, input int kernal_size);
        return ifm_size - kernal_size + 1;
    endfunction

    // Width of a row or column index.
    function automatic int calc_pos_w(input int ifm_size, input int kernal_size);
        return $clog2(calc_os(ifm_size, kernal_size));
    endfunction

    // Width of a flattened row*OS+col output address.
    function automatic int calc_addr_w(input int ifm_size, input int kernal_size);
        int os;
        os = calc_os(ifm_size, kernal_size);
        return $clog2(os * os);
    endfunction

    // Width of an index that counts up to n-1, never narrower than one bit.
    function automatic int calc_sel_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int calc_d_w(input int ifm_depth);
        return calc_sel_w(ifm_depth);
    endfunction

    function automatic int calc_f_w(input int number_of_filters);
        return calc_sel_w(number_of_filters);
    endfunction

    localparam int DEF_ADDR_W = calc_addr_w(DEF_IFM_SIZE, DEF_KERNAL_SIZE);
    localparam int DEF_F_W    = calc_f_w(DEF_NUMBER_OF_FILTERS);

    // Metadata that travels alongside a window through the datapath. The
    // valid flag is the first field, so it is the MSB of the packed record.
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_F_W-1:0]    filter;
        logic                  first;
        logic                  last;
    } tag_t;

endpackage

// File: rtl/conv_sequencer_tag_pipe.sv
// Fixed-depth shift register that carries result tags in lockstep with the
// ungated adder tree. The MSB of each entry is its valid flag.
module tag_pipe #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_pending
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift every cycle; stage 0 takes the new entry.
    // NOTE: every stage is reset because the valid flags must read 0 after reset; a data-only RAM would not need this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

    // A valid entry will still be in flight after the next shift.
    // NOTE: o_pending gets a default first so no path through the loop can leave it unassigned and infer a latch.
    always_comb begin
        o_pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            o_pending = o_pending | r_stage[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Sequencer for one 5x5 convolution unit: walks filter/depth/row/col across a
// layer, strobes the multiplier register, and tags each result that emerges
// from the fixed-latency datapath with its address and accumulation flags.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IFM_SIZE          = 14,
    parameter int IFM_DEPTH         = 3,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 2,
    localparam int OS     = calc_os(IFM_SIZE, KERNAL_SIZE),
    localparam int POS_W  = calc_pos_w(IFM_SIZE, KERNAL_SIZE),
    localparam int ADDR_W = calc_addr_w(IFM_SIZE, KERNAL_SIZE),
    localparam int D_W    = calc_d_w(IFM_DEPTH),
    localparam int F_W    = calc_f_w(NUMBER_OF_FILTERS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              win_valid,
    input  logic              hold,
    output logic              conv_enable,
    output logic [POS_W-1:0]  win_row,
    output logic [POS_W-1:0]  win_col,
    output logic [D_W-1:0]    depth_sel,
    output logic [F_W-1:0]    filter_sel,
    output logic              win_advance,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [F_W-1:0]    out_filter,
    output logic              out_first,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Same layout as conv_pkg::tag_t, sized for this instance's geometry.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [F_W-1:0]    filter;
        logic              first;
        logic              last;
    } tag_rec_t;

    localparam int TAG_W = $bits(tag_rec_t);

    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(OS - 1);
    localparam logic [D_W-1:0]   DEPTH_LAST = D_W'(IFM_DEPTH - 1);
    localparam logic [F_W-1:0]   FILT_LAST  = F_W'(NUMBER_OF_FILTERS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [POS_W-1:0] r_row;
    logic [POS_W-1:0] r_col;
    logic [D_W-1:0]   r_depth;
    logic [F_W-1:0]   r_filter;

    logic             w_issue;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_depth_last;
    logic             w_filter_last;
    logic             w_final_issue;
    logic             w_pipe_pending;
    tag_rec_t         w_tag_in;
    tag_rec_t         w_tag_out;

    // A window is consumed only while running, present and not back-pressured.
    assign w_issue       = (r_state == ST_RUN) && win_valid && !hold;
    assign w_col_last    = (r_col == POS_LAST);
    assign w_row_last    = (r_row == POS_LAST);
    assign w_depth_last  = (r_depth == DEPTH_LAST);
    assign w_filter_last = (r_filter == FILT_LAST);
    assign w_final_issue = w_issue && w_col_last && w_row_last && w_depth_last && w_filter_last;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start)           w_state_next = ST_RUN;
            ST_RUN:   if (w_final_issue)   w_state_next = ST_DRAIN;
            ST_DRAIN: if (!w_pipe_pending) w_state_next = ST_DONE;
            ST_DONE:                       w_state_next = ST_IDLE;
            default:                       w_state_next = ST_IDLE;
        endcase
    end

    // Window counters: col innermost, then row, depth, filter; cleared on entry to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row    <= '0;
            r_col    <= '0;
            r_depth  <= '0;
            r_filter <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_row    <= '0;
            r_col    <= '0;
            r_depth  <= '0;
            r_filter <= '0;
        end else if (w_issue) begin
            if (!w_col_last) begin
                r_col <= r_col + 1'b1;
            end else begin
                r_col <= '0;
                if (!w_row_last) begin
                    r_row <= r_row + 1'b1;
                end else begin
                    r_row <= '0;
                    if (!w_depth_last) begin
                        r_depth <= r_depth + 1'b1;
                    end else begin
                        r_depth  <= '0;
                        r_filter <= w_filter_last ? '0 : r_filter + 1'b1;
                    end
                end
            end
        end
    end

    // Metadata for the window being issued; idle cycles insert an empty tag so
    // values the datapath recomputes while the mul register holds are never flagged.
    always_comb begin
        w_tag_in = '0;
        if (w_issue) begin
            w_tag_in.valid  = 1'b1;
            w_tag_in.addr   = ADDR_W'(int'(r_row) * OS + int'(r_col));
            w_tag_in.filter = r_filter;
            w_tag_in.first  = (r_depth == '0);
            w_tag_in.last   = w_depth_last;
        end
    end

    tag_pipe #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (TAG_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (reset),
        .i_data    (w_tag_in),
        .o_data    (w_tag_out),
        .o_pending (w_pipe_pending)
    );

    assign conv_enable = w_issue;
    assign win_advance = w_issue;
    assign win_row     = r_row;
    assign win_col     = r_col;
    assign depth_sel   = r_depth;
    assign filter_sel  = r_filter;

    assign out_valid   = w_tag_out.valid;
    assign out_addr    = w_tag_out.addr;
    assign out_filter  = w_tag_out.filter;
    assign out_first   = w_tag_out.first;
    assign out_last    = w_tag_out.last;

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);

endmodule
